// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_pkg
// Shared types and constants for the AXI-Lite request arbiter.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_WRESP = 3'd4,
    ST_RESP  = 3'd5
  } arb_state_t;

  // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp & RESP_SLVERR) != RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first active request found when
// scanning upward from the requester after the previous winner.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GID_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [GID_W-1:0]   grant_id_o,
  output logic               any_grant_o
);

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); the previous winner is checked last.
  always_comb begin
    logic [GID_W-1:0] idx;
    grant_o     = '0;
    grant_id_o  = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = GID_W'((int'(last_i) + off) % NUM_REQ);
      if (!any_grant_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_req_arbiter
// Shares one AXI-Lite master port between NUM_REQ local requesters, one
// single-beat command at a time, round-robin, with a one-cycle response pulse.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module axi_lite_req_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  // Requester side
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [GID_W-1:0]          grant_id,
  // AW channel
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_W-1:0]         awaddr,
  // W channel
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_W-1:0]         wdata,
  output logic [STRB_W-1:0]         wstrb,
  // B channel
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  // AR channel
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_W-1:0]         araddr,
  // R channel
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp
);

  arb_state_t          state_q;
  logic [GID_W-1:0]    grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                busy_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [GID_W-1:0]    arb_gid;
  logic                arb_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                sel_write;
  logic                aw_done_d;
  logic                w_done_d;
  logic [NUM_REQ-1:0]  grant_dec;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .last_i      (grant_q),
    .grant_o     (arb_grant),
    .grant_id_o  (arb_gid),
    .any_grant_o (arb_any)
  );

  // Route the winning requester's command fields to the latch inputs.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
        sel_write = req_write[i];
      end
    end
  end

  // AW and W complete independently; either may finish first or both together.
  assign aw_done_d = aw_done_q | (awvalid_q & awready);
  assign w_done_d  = w_done_q  | (wvalid_q  & wready);
  assign grant_dec = NUM_REQ'(1) << grant_q;

  // Main sequencer: one outstanding transaction, all handshake outputs registered.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GID_W'(NUM_REQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gid;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            busy_q  <= 1'b1;
            if (sel_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RADDR;
            end
          end
        end
        ST_RADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rdata_q     <= rdata;
            err_q       <= resp_is_err(rresp);
            rsp_valid_q <= grant_dec;
            state_q     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          awvalid_q <= ~aw_done_d;
          wvalid_q  <= ~w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= resp_is_err(bresp);
            rsp_valid_q <= grant_dec;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Accept is combinational so the winner sees ready in its request cycle.
  assign req_ready = (areset_n && state_q == ST_IDLE) ? arb_grant : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign rready    = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_axi_lite_req_arbiter
// Directed bench: a vector table of single transactions against a zero-wait
// slave, plus hand-written sequences for the multi-cycle corner cases.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_axi_lite_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int GID_W   = 1;

  logic                  aclk = 1'b0;
  logic                  areset_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NUM_REQ*32-1:0] req_addr, req_wdata;
  logic [NUM_REQ*4-1:0]  req_wstrb;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err, busy;
  logic [GID_W-1:0]      grant_id;
  logic                  awvalid, awready, wvalid, wready, bvalid, bready;
  logic                  arvalid, arready, rvalid, rready;
  logic [31:0]           awaddr, wdata, araddr, rdata;
  logic [3:0]            wstrb;
  logic [1:0]            bresp, rresp;

  // Slave: either a zero-wait auto responder or manually driven per cycle.
  logic        auto_mode;
  logic        m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
  logic [31:0] m_rdata, a_rdata;
  logic [1:0]  m_rresp, m_bresp, a_rresp, a_bresp;
  logic        a_rpend, a_bpend;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  assign arready = auto_mode ? 1'b1    : m_arready;
  assign awready = auto_mode ? 1'b1    : m_awready;
  assign wready  = auto_mode ? 1'b1    : m_wready;
  assign rvalid  = auto_mode ? a_rpend : m_rvalid;
  assign bvalid  = auto_mode ? a_bpend : m_bvalid;
  assign rdata   = auto_mode ? a_rdata : m_rdata;
  assign rresp   = auto_mode ? a_rresp : m_rresp;
  assign bresp   = auto_mode ? a_bresp : m_bresp;

  always @(posedge aclk) begin
    if (!auto_mode || !areset_n) begin
      a_rpend <= 1'b0;
      a_bpend <= 1'b0;
    end else begin
      if (arvalid && arready)                          a_rpend <= 1'b1;
      else if (rvalid && rready)                       a_rpend <= 1'b0;
      if (awvalid && wvalid && awready && wready)      a_bpend <= 1'b1;
      else if (bvalid && bready)                       a_bpend <= 1'b0;
    end
  end

  axi_lite_req_arbiter #(.NUM_REQ(NUM_REQ), .GID_W(GID_W)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  typedef struct {
    int          rid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] sdata;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns 1 ns after the rising edge so registered outputs have settled.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive_req(input int rid, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st);
    req_write[rid]         = wr;
    req_addr[rid*32 +: 32] = addr;
    req_wdata[rid*32 +: 32] = wd;
    req_wstrb[rid*4 +: 4]  = st;
    req_valid[rid]         = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 40) begin
      step();
      c++;
    end
    chk(nm, busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    step();
    a_rdata   = v.sdata;
    a_rresp   = v.sresp;
    a_bresp   = v.sresp;
    req_addr  = {NUM_REQ{32'hBAD0BAD0}};
    req_wdata = {NUM_REQ{32'h0BAD0BAD}};
    req_wstrb = {NUM_REQ{4'hA}};
    req_write = {NUM_REQ{~v.wr}};
    drive_req(v.rid, v.wr, v.addr, v.wdata, v.wstrb);
    #1;
    chk($sformatf("v%0d_accept", k), req_ready, oh(v.rid));
    step();
    req_valid = '0;
    chk($sformatf("v%0d_busy", k), busy, 1'b1);
    if (!v.wr) begin
      chk($sformatf("v%0d_arvalid", k), arvalid, 1'b1);
      chk($sformatf("v%0d_araddr", k), araddr, v.addr);
    end else begin
      chk($sformatf("v%0d_awwvalid", k), {awvalid, wvalid}, 2'b11);
      chk($sformatf("v%0d_awaddr", k), awaddr, v.addr);
      chk($sformatf("v%0d_wdata", k), {wdata, wstrb}, {v.wdata, v.wstrb});
    end
    step();
    if (!v.wr) chk($sformatf("v%0d_rphase", k), {rready, arvalid}, 2'b10);
    else       chk($sformatf("v%0d_bphase", k), {bready, awvalid, wvalid}, 3'b100);
    step();
    chk($sformatf("v%0d_rsp_valid", k), rsp_valid, oh(v.rid));
    chk($sformatf("v%0d_rsp_rdata", k), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rsp_err", k), rsp_err, v.exp_err);
    chk($sformatf("v%0d_grant_id", k), grant_id, v.rid);
    step();
    chk($sformatf("v%0d_done", k), {rsp_valid, busy}, 3'b000);
  endtask

  initial begin
    logic [NUM_REQ-1:0] cont_exp [4];
    int cyc;

    vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00, 32'h0,         1'b0};
    vecs[2] = '{1, 1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D, 1'b1};
    vecs[3] = '{0, 1'b1, 32'h0000_0030, 32'h0000_A5A5, 4'h3, 32'h0,         2'b11, 32'h0,         1'b1};
    vecs[4] = '{0, 1'b0, 32'h0000_0034, 32'h0,         4'h0, 32'h5555_AAAA, 2'b01, 32'h5555_AAAA, 1'b0};
    cont_exp[0] = 2'b01; cont_exp[1] = 2'b10; cont_exp[2] = 2'b01; cont_exp[3] = 2'b10;

    areset_n  = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    auto_mode = 1'b0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    a_rdata = '0; a_rresp = '0; a_bresp = '0;

    // Reset state
    repeat (3) step();
    areset_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
    chk("rst_axi", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("rst_req_ready", req_ready, 2'b00);

    // Contention: both requesters hold valid; grants must alternate 0,1,0,1.
    auto_mode = 1'b1;
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
    drive_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    for (int t = 0; t < 4; t++) begin
      #1;
      cyc = 0;
      while (req_ready == '0 && cyc < 12) begin
        step();
        #1;
        cyc++;
      end
      chk($sformatf("cont_grant%0d", t), req_ready, cont_exp[t]);
      step();
      #1;
      chk($sformatf("cont_pulse%0d", t), req_ready, 2'b00);
    end
    req_valid = '0;
    wait_idle("cont_idle");

    // Table of single transactions against the zero-wait slave
    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);
    auto_mode = 1'b0;

    // Single read with arready and rvalid each one cycle late
    step();
    drive_req(0, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
    #1; chk("A_accept", req_ready, 2'b01);
    step(); req_valid = '0;
    chk("A_arvalid_c1", arvalid, 1'b1);
    step();
    chk("A_arvalid_c2", {arvalid, araddr}, {1'b1, 32'h0000_0008});
    m_arready = 1'b1;
    step(); m_arready = 1'b0;
    chk("A_rready", {rready, arvalid}, 2'b10);
    step();
    chk("A_no_early_rsp", rsp_valid, 2'b00);
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
    step(); m_rvalid = 1'b0;
    chk("A_rsp", {rsp_valid, rsp_rdata, rsp_err}, {2'b01, 32'hDEAD_BEEF, 1'b0});
    step();
    chk("A_rsp_pulse", {rsp_valid, busy}, 3'b000);

    // Write with W accepted before AW, slave returns SLVERR
    step();
    drive_req(1, 1'b1, 32'h0000_0004, 32'h0000_005A, 4'b0001);
    m_wready = 1'b1;
    #1; chk("B_accept", req_ready, 2'b10);
    step(); req_valid = '0;
    chk("B_valids_c1", {awvalid, wvalid}, 2'b11);
    chk("B_wdata", {wdata, wstrb}, {32'h0000_005A, 4'b0001});
    step(); m_wready = 1'b0;
    chk("B_w_dropped", {awvalid, wvalid, awaddr}, {2'b10, 32'h0000_0004});
    step();
    chk("B_aw_held_c3", {awvalid, wvalid, bready}, 3'b100);
    m_awready = 1'b1;
    step(); m_awready = 1'b0;
    chk("B_bready", {awvalid, wvalid, bready}, 3'b001);
    m_bvalid = 1'b1; m_bresp = 2'b10;
    step(); m_bvalid = 1'b0;
    chk("B_rsp", {rsp_valid, rsp_rdata, rsp_err}, {2'b10, 32'h0, 1'b1});
    step();
    chk("B_rsp_pulse", rsp_valid, 2'b00);

    // AW and W accepted in the same cycle
    step();
    m_awready = 1'b1; m_wready = 1'b1;
    drive_req(0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF);
    #1; chk("D_accept", req_ready, 2'b01);
    step(); req_valid = '0;
    chk("D_valids_c1", {awvalid, wvalid}, 2'b11);
    step(); m_awready = 1'b0; m_wready = 1'b0;
    chk("D_drop_both", {awvalid, wvalid, bready}, 3'b001);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step(); m_bvalid = 1'b0;
    chk("D_rsp", {rsp_valid, rsp_err}, 3'b010);
    step();
    chk("D_idle", busy, 1'b0);

    // arready held low for 10 cycles while another requester waits
    step();
    drive_req(1, 1'b0, 32'h1000_00C0, 32'h0, 4'h0);
    #1; chk("E_accept", req_ready, 2'b10);
    step();
    req_valid = '0;
    drive_req(0, 1'b0, 32'h0000_0077, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("E_hold%0d", i), {arvalid, araddr, busy, req_ready},
          {1'b1, 32'h1000_00C0, 1'b1, 2'b00});
      step();
    end
    req_valid = '0;
    m_arready = 1'b1;
    #1; chk("E_arvalid_end", arvalid, 1'b1);
    step(); m_arready = 1'b0;
    chk("E_rready", rready, 1'b1);
    m_rvalid = 1'b1; m_rdata = 32'h0000_0C0C; m_rresp = 2'b00;
    step(); m_rvalid = 1'b0;
    chk("E_rsp", {rsp_valid, rsp_rdata}, {2'b10, 32'h0000_0C0C});
    step();
    chk("E_idle", busy, 1'b0);

    // Reset while waiting for the write response
    step();
    m_awready = 1'b1; m_wready = 1'b1;
    drive_req(0, 1'b1, 32'h0000_0050, 32'h0000_FACE, 4'hF);
    #1; chk("F_accept", req_ready, 2'b01);
    step(); req_valid = '0;
    step(); m_awready = 1'b0; m_wready = 1'b0;
    chk("F_in_wresp", {bready, grant_id}, 2'b10);
    areset_n = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step();
    chk("F_rst_axi", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("F_rst_state", {rsp_valid, busy, grant_id}, 4'b0001);
    step();
    chk("F_no_rsp", {rsp_valid, req_ready}, 4'b0000);
    m_bvalid = 1'b0;
    areset_n = 1'b1;
    drive_req(0, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
    drive_req(1, 1'b0, 32'h0000_0064, 32'h0, 4'h0);
    #1; chk("F_first_after_rst", req_ready, 2'b01);
    step(); req_valid = '0;
    chk("F_grant_id", grant_id, 1'b0);
    auto_mode = 1'b1;
    wait_idle("F_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
